// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-path types, FSM encoding and default widths.
package cpu_pkg;
  localparam int XLEN_DEFAULT = 32;
  typedef enum logic [1:0] {BOOT, RUN, DRAIN, HALT} fetch_state_t;
  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [31:0]             data;
    logic                    fault;
    logic                    filled;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: circular prefetch buffer; entries are reserved in request order and filled in response order.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     reserve,
  input  logic [XLEN-1:0]          reserve_pc,
  input  logic                     fill,
  input  logic [31:0]              fill_data,
  input  logic                     fill_fault,
  input  logic                     pop,
  output logic                     head_valid,
  output logic [XLEN-1:0]          head_pc,
  output logic [31:0]              head_data,
  output logic                     head_fault,
  output logic [$clog2(DEPTH):0]   filled_count
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t mem [DEPTH];
  fetch_entry_t head;
  logic [AW:0] wr_ptr, fill_ptr, rd_ptr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      fill_ptr <= '0;
      rd_ptr   <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      fill_ptr <= '0;
      rd_ptr   <= '0;
    end else begin
      if (reserve) begin
        mem[wr_ptr[AW-1:0]] <= '{pc: XLEN_DEFAULT'(reserve_pc), data: 32'd0, fault: 1'b0, filled: 1'b0};
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (fill) begin
        mem[fill_ptr[AW-1:0]].data   <= fill_fault ? 32'd0 : fill_data;
        mem[fill_ptr[AW-1:0]].fault  <= fill_fault;
        mem[fill_ptr[AW-1:0]].filled <= 1'b1;
        fill_ptr <= fill_ptr + (AW+1)'(1);
      end
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end
  // Reserving clears the filled flag, so a stale flag can never surface at an empty head.
  assign head         = mem[rd_ptr[AW-1:0]];
  assign head_valid   = head.filled && (rd_ptr != wr_ptr);
  assign head_pc      = head_valid ? XLEN'(head.pc) : '0;
  assign head_data    = head_valid ? head.data : 32'd0;
  assign head_fault   = head_valid && head.fault;
  assign filled_count = fill_ptr - rd_ptr;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: prefetching instruction fetch with redirect flush and stale-response draining.
// Optional misaligned-redirect trap and HALT state enabled by FETCH_MISALIGN_TRAP_EN.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr_data,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_fault,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_addr,
  output logic            trap_misalign
);
  localparam int CW = $clog2(DEPTH) + 1;
  fetch_state_t    state, state_nx;
  logic [XLEN-1:0] pc, pc_nx, target;
  logic [CW-1:0]   outstanding, outstanding_nx, discard, discard_nx, filled_count;
  logic            redirect, accept, rsp_take, fill, pop, misaligned;
  assign redirect = redirect_valid && (state != BOOT);
`ifdef FETCH_MISALIGN_TRAP_EN
  assign misaligned = redirect_addr[1:0] != 2'b00;
`else
  assign misaligned = 1'b0;
`endif
  assign target = redirect_addr & ~XLEN'(3);
  // Outstanding already covers reserved-but-unfilled entries, so only filled ones add to it.
  assign imem_req_valid = (state == RUN || state == DRAIN) && !redirect_valid &&
                          ((CW+1)'(filled_count) + (CW+1)'(outstanding) < (CW+1)'(DEPTH));
  assign imem_req_addr  = pc;
  assign accept   = imem_req_valid && imem_req_ready;
  assign rsp_take = imem_rsp_valid && (outstanding != '0);
  assign fill     = rsp_take && !redirect && (discard == '0);
  assign pop      = instr_valid && instr_ready && !redirect;
  always_comb begin
    outstanding_nx = outstanding + CW'(accept) - CW'(rsp_take);
    discard_nx     = redirect ? outstanding_nx : discard - CW'(rsp_take && discard != '0);
    pc_nx          = redirect ? (misaligned ? pc : target) : (accept ? pc + XLEN'(4) : pc);
    state_nx       = state == BOOT ? RUN :
                     redirect      ? (misaligned ? HALT : (outstanding_nx != '0 ? DRAIN : RUN)) :
                     (state == DRAIN && discard_nx == '0) ? RUN : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= BOOT;
      pc            <= RESET_PC;
      outstanding   <= '0;
      discard       <= '0;
      trap_misalign <= 1'b0;
    end else begin
      state         <= state_nx;
      pc            <= pc_nx;
      outstanding   <= outstanding_nx;
      discard       <= discard_nx;
      trap_misalign <= redirect && misaligned;
    end
  end
  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) u_queue (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (redirect),
    .reserve      (accept),
    .reserve_pc   (pc),
    .fill         (fill),
    .fill_data    (imem_rsp_data),
    .fill_fault   (imem_rsp_err),
    .pop          (pop),
    .head_valid   (instr_valid),
    .head_pc      (instr_pc),
    .head_data    (instr_data),
    .head_fault   (instr_fault),
    .filled_count (filled_count)
  );
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized memory/decode/redirect traffic checked against a transaction-level fetch-stream model.
module tb_instr_fetch_unit;
  localparam int DEPTH = 4;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0, imem_rsp_err = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        instr_valid, instr_ready = 1'b0, instr_fault;
  logic [31:0] instr_data, instr_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic        trap_misalign;

  always #5 clk = ~clk;

  instr_fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
    .instr_pc(instr_pc), .instr_fault(instr_fault),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .trap_misalign(trap_misalign)
  );

  typedef struct {logic [31:0] addr; int due; int epoch;} pend_t;
  typedef struct {logic [31:0] pc; logic [31:0] data; logic fault;} ins_t;
  pend_t       pending[$];
  ins_t        exp_q[$], hs_log[$];
  logic [31:0] acc_log[$];
  logic [31:0] m_pc, first_valid_pc;
  int          cyc, epoch, rsp_idx, err_idx, first_valid_cyc;
  int          k_ready, k_iready, k_redir, k_err, lat_lo, lat_hi;
  int          n_tests = 0, n_fail = 0;
  bit          halted, exp_trap, rel, s_valid, s_rsp;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    {imem_req_ready, imem_rsp_valid, imem_rsp_err, instr_ready, redirect_valid} = '0;
    imem_rsp_data = '0;
    pending.delete(); exp_q.delete();
    halted = 0; exp_trap = 0; m_pc = 32'h0; epoch++; rsp_idx = 0; err_idx = 0;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr_fault", 32'(instr_fault), 32'd0);
    chk("rst_instr_data", instr_data, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_trap", 32'(trap_misalign), 32'd0);
    repeat (2) @(posedge clk);
    rel = 1; cyc = -1;
  endtask

  task automatic tick(input bit force_redir, input logic [31:0] raddr);
    pend_t p;
    bit    exp_rv;
    @(posedge clk); #1;
    if (rel) begin rst_n = 1'b1; rel = 0; end
    cyc++;
    imem_req_ready = int'($urandom_range(99)) < k_ready;
    instr_ready    = int'($urandom_range(99)) < k_iready;
    redirect_valid = force_redir || (cyc >= 1 && int'($urandom_range(999)) < k_redir);
    redirect_addr  = force_redir ? raddr :
                     ($urandom_range(3) == 0 ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : ($urandom & 32'h0000_0FFF));
    imem_rsp_valid = 1'b0; imem_rsp_err = 1'b0; imem_rsp_data = '0;
    if (pending.size() > 0 && pending[0].due <= cyc) begin
      rsp_idx++;
      imem_rsp_valid = 1'b1;
      imem_rsp_err   = (rsp_idx == err_idx) || (int'($urandom_range(99)) < k_err);
      imem_rsp_data  = imem_rsp_err ? $urandom : mem_word(pending[0].addr);
    end
    @(negedge clk);
    exp_rv = cyc >= 1 && !halted && !redirect_valid && (exp_q.size() + pending.size() < DEPTH);
    chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    if (exp_rv) chk("req_addr", imem_req_addr, m_pc);
    chk("instr_valid", 32'(instr_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("instr_pc", instr_pc, exp_q[0].pc);
      chk("instr_data", instr_data, exp_q[0].data);
      chk("instr_fault", 32'(instr_fault), 32'(exp_q[0].fault));
    end
    chk("trap", 32'(trap_misalign), 32'(exp_trap));
    s_valid = instr_valid; s_rsp = imem_rsp_valid;
    if (instr_valid && first_valid_cyc < 0) begin first_valid_cyc = cyc; first_valid_pc = instr_pc; end
    if (exp_q.size() != 0 && instr_ready && !redirect_valid) hs_log.push_back(exp_q.pop_front());
    if (imem_rsp_valid) begin
      p = pending.pop_front();
      if (p.epoch == epoch && !redirect_valid)
        exp_q.push_back('{p.addr, imem_rsp_err ? 32'd0 : imem_rsp_data, imem_rsp_err});
    end
    if (exp_rv && imem_req_ready) begin
      pending.push_back('{m_pc, cyc + int'($urandom_range(lat_hi, lat_lo)), epoch});
      acc_log.push_back(m_pc);
      m_pc += 32'd4;
    end
    exp_trap = 0;
    if (redirect_valid) begin
      epoch++;
      exp_q.delete();
      if (TRAP_EN && redirect_addr[1:0] != 2'b00) begin halted = 1; exp_trap = 1; end
      else begin halted = 0; m_pc = redirect_addr & 32'hFFFF_FFFC; end
    end
  endtask

  initial begin
    k_ready = 100; k_iready = 0; k_redir = 0; k_err = 0; lat_lo = 1; lat_hi = 1;
    epoch = 0; cyc = -1;
    // Back-pressured decode: boot timing, first four addresses, then one request per pop
    do_reset();
    acc_log.delete(); first_valid_cyc = -1;
    repeat (20) tick(0, 0);
    chk("bp_accepts", acc_log.size(), 4);
    if (acc_log.size() == 4) begin
      chk("bp_addr0", acc_log[0], 32'h0);
      chk("bp_addr1", acc_log[1], 32'h4);
      chk("bp_addr2", acc_log[2], 32'h8);
      chk("bp_addr3", acc_log[3], 32'hC);
    end
    chk("first_valid_cycle", first_valid_cyc, 3);
    chk("first_valid_pc", first_valid_pc, 32'h0);
    k_iready = 100; tick(0, 0); k_iready = 0;
    repeat (10) tick(0, 0);
    chk("pop_one_accept", acc_log.size(), 5);
    if (acc_log.size() == 5) chk("pop_next_addr", acc_log[4], 32'h10);

    // Error on the third response
    do_reset();
    err_idx = 3; k_iready = 100; hs_log.delete();
    repeat (12) tick(0, 0);
    chk("err_hs_count", 32'(hs_log.size() >= 4), 32'd1);
    if (hs_log.size() >= 4) begin
      chk("err_pc", hs_log[2].pc, 32'h8);
      chk("err_fault", 32'(hs_log[2].fault), 32'd1);
      chk("err_data", hs_log[2].data, 32'd0);
      chk("err_next_pc", hs_log[3].pc, 32'hC);
      chk("err_next_fault", 32'(hs_log[3].fault), 32'd0);
    end

    // Redirect with two requests in flight
    do_reset();
    lat_lo = 3; lat_hi = 3;
    for (int i = 0; i < 20 && pending.size() != 2; i++) tick(0, 0);
    chk("redir_two_inflight", pending.size(), 2);
    hs_log.delete();
    tick(1, 32'h100);
    repeat (15) tick(0, 0);
    chk("redir_hs_seen", 32'(hs_log.size() > 0), 32'd1);
    if (hs_log.size() > 0) chk("redir_first_pc", hs_log[0].pc, 32'h100);

    // PC wrap at the top of the address space
    lat_lo = 1; lat_hi = 1;
    repeat (4) tick(0, 0);
    acc_log.delete();
    tick(1, 32'hFFFF_FFF8);
    repeat (6) tick(0, 0);
    chk("wrap_count", 32'(acc_log.size() >= 3), 32'd1);
    if (acc_log.size() >= 3) begin
      chk("wrap_a0", acc_log[0], 32'hFFFF_FFF8);
      chk("wrap_a1", acc_log[1], 32'hFFFF_FFFC);
      chk("wrap_a2", acc_log[2], 32'h0);
    end

    // Redirect, pop and response in one cycle
    acc_log.delete();
    tick(1, 32'h300);
    chk("same_cycle_setup", 32'(s_valid && s_rsp && instr_ready), 32'd1);
    tick(0, 0);
    chk("same_cycle_empty", 32'(instr_valid), 32'd0);
    repeat (4) tick(0, 0);
    if (acc_log.size() > 0) chk("same_cycle_pc", acc_log[0], 32'h300);
    else chk("same_cycle_pc", 32'hDEAD_DEAD, 32'h300);

    // Misaligned redirect
    acc_log.delete();
    tick(1, 32'h102);
`ifdef FETCH_MISALIGN_TRAP_EN
    tick(0, 0);
    chk("trap_pulse", 32'(trap_misalign), 32'd1);
    repeat (8) tick(0, 0);
    chk("trap_pulse_end", 32'(trap_misalign), 32'd0);
    chk("halt_no_req", acc_log.size(), 0);
    tick(1, 32'h200);
    repeat (4) tick(0, 0);
    if (acc_log.size() > 0) chk("halt_resume", acc_log[0], 32'h200);
    else chk("halt_resume", 32'hDEAD_DEAD, 32'h200);
`else
    repeat (4) tick(0, 0);
    chk("no_trap", 32'(trap_misalign), 32'd0);
    if (acc_log.size() > 0) chk("force_align", acc_log[0], 32'h100);
    else chk("force_align", 32'hDEAD_DEAD, 32'h100);
`endif

    // Random traffic, with a reset in the middle of it
    k_ready = 70; k_iready = 60; k_redir = 30; k_err = 10; lat_lo = 1; lat_hi = 4;
    repeat (1500) tick(0, 0);
    do_reset();
    acc_log.delete();
    repeat (1500) tick(0, 0);
    if (acc_log.size() > 0) chk("post_reset_first", acc_log[0], 32'h0);
    else chk("post_reset_first", 32'hDEAD_DEAD, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
